// File: rtl/capture_write_arbiter.sv
// Round-robin arbiter sharing one word writer among NUM_CH capture streams.
// Each grant emits a channel/sequence tag word, then up to MAX_BURST data beats closed by wr_file.
module capture_write_arbiter #(
  parameter  int NUM_CH    = 4,
  parameter  int NUM_BYTES = 2,
  parameter  int MAX_BURST = 256,
  localparam int W         = NUM_BYTES * 8,
  localparam int GW        = $clog2(NUM_CH),
  localparam int SW        = W - 8,
  localparam int BW        = $clog2(MAX_BURST)
) (
  input  logic                clk,
  input  logic                async_reset_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   in_valid,
  input  logic [NUM_CH*W-1:0] in_word,
  input  logic [NUM_CH-1:0]   in_last,
  output logic [NUM_CH-1:0]   in_rdy,
  output logic                out_valid,
  output logic [W-1:0]        out_word,
  output logic                out_wr_file,
  input  logic                out_rdy,
  output logic [GW-1:0]       grant_idx,
  output logic                busy,
  output logic [31:0]         burst_total
);

  typedef enum logic [1:0] {ST_IDLE, ST_TAG, ST_DATA} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] rr_next;
  logic [GW-1:0] req_ch;
  logic          req_found;
  logic [SW-1:0] seq [NUM_CH];
  logic [BW-1:0] beat_cnt;
  logic          g_valid;
  logic          g_end;
  logic          g_xfer;
  logic [W-1:0]  g_word;
  int            idx;

  // First requester at or above rr_ptr, wrapping around the channel list.
  always_comb begin
    req_found = 1'b0;
    req_ch    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!req_found && in_valid[idx]) begin
        req_found = 1'b1;
        req_ch    = GW'(idx);
      end
    end
  end

  assign rr_next = (grant_idx == GW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
  assign g_valid = in_valid[grant_idx];
  assign g_word  = in_word[grant_idx*W +: W];
  // A burst ends on the source's marker or when the beat budget is used up.
  assign g_end   = in_last[grant_idx] | (beat_cnt == BW'(MAX_BURST - 1));
  assign g_xfer  = g_valid & out_rdy;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt   = state;
    out_valid   = 1'b0;
    out_word    = '0;
    out_wr_file = 1'b0;
    in_rdy      = '0;
    unique case (state)
      ST_IDLE: begin
        if (enable && req_found) state_nxt = ST_TAG;
      end
      ST_TAG: begin
        out_valid = 1'b1;
        out_word  = {8'(grant_idx), seq[grant_idx]};
        if (out_rdy) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        out_valid         = g_valid;
        out_word          = g_word;
        out_wr_file       = g_valid & g_end;
        in_rdy[grant_idx] = out_rdy;
        if (g_xfer && g_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      rr_ptr      <= '0;
      grant_idx   <= '0;
      beat_cnt    <= '0;
      burst_total <= '0;
      // NOTE: the sequence table is small and must restart at zero, so it is reset explicitly.
      for (int i = 0; i < NUM_CH; i++) seq[i] <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (enable && req_found) grant_idx <= req_ch;
        end
        ST_TAG: begin
          if (out_rdy) beat_cnt <= '0;
        end
        ST_DATA: begin
          if (g_xfer) begin
            if (g_end) begin
              seq[grant_idx] <= seq[grant_idx] + 1'b1;
              rr_ptr         <= rr_next;
              burst_total    <= burst_total + 32'd1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_write_arbiter.sv
// Self-checking bench for capture_write_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a burst-level reference model and a per-channel scoreboard.
module tb_capture_write_arbiter;
  localparam int NUM_CH    = 4;
  localparam int NUM_BYTES = 2;
  localparam int MAX_BURST = 4;
  localparam int W         = NUM_BYTES * 8;
  localparam int GW        = 2;

  logic                clk = 1'b0;
  logic                async_reset_n = 1'b0;
  logic                enable = 1'b0;
  logic                out_rdy = 1'b0;
  logic [NUM_CH-1:0]   in_valid = '0;
  logic [NUM_CH-1:0]   in_last = '0;
  logic [NUM_CH*W-1:0] in_word = '0;
  logic [NUM_CH-1:0]   in_rdy;
  logic                out_valid;
  logic [W-1:0]        out_word;
  logic                out_wr_file;
  logic [GW-1:0]       grant_idx;
  logic                busy;
  logic [31:0]         burst_total;

  capture_write_arbiter #(
    .NUM_CH(NUM_CH), .NUM_BYTES(NUM_BYTES), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .async_reset_n(async_reset_n), .enable(enable),
    .in_valid(in_valid), .in_word(in_word), .in_last(in_last), .in_rdy(in_rdy),
    .out_valid(out_valid), .out_word(out_word), .out_wr_file(out_wr_file), .out_rdy(out_rdy),
    .grant_idx(grant_idx), .busy(busy), .burst_total(burst_total)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-channel sources: queued words with their end markers.
  logic [W-1:0] src_w [NUM_CH][$];
  bit           src_l [NUM_CH][$];
  bit           hold [NUM_CH];
  int           present_pct = 100;
  int           rdy_mode = 0;   // 0 keep, 1 toggle, 2 random
  int           en_mode = 0;    // 0 keep, 2 random

  // Burst-level reference: which channel owns the writer and whether its tag is still owed.
  int m_owner, m_beats, m_rr, m_g, m_total;
  bit m_tag;
  int m_seq [NUM_CH];

  // Output transfer log {wr_file, word} and scoreboard of per-channel serials.
  logic [16:0]  log_q[$];
  logic [16:0]  exp_log[$];
  bit           sb_on = 0;
  int           exp_serial [NUM_CH];
  int           produced [NUM_CH];
  logic [W-1:0] seen_word;

  task automatic push(int ch, logic [W-1:0] w, bit l);
    src_w[ch].push_back(w);
    src_l[ch].push_back(l);
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < NUM_CH; i++) if (src_w[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic step();
    bit              show, e_ov, e_wf, e_end, found;
    logic [W-1:0]    e_w;
    logic [NUM_CH-1:0] e_rdy;
    logic [56:0]     act_v, exp_v;
    int              c;
    for (int i = 0; i < NUM_CH; i++) begin
      show = (src_w[i].size() > 0) && (hold[i] || ($urandom_range(99) < present_pct));
      in_valid[i]       = show;
      in_word[i*W +: W] = show ? src_w[i][0] : W'($urandom);
      in_last[i]        = show ? src_l[i][0] : 1'($urandom);
      hold[i]           = show;
    end
    @(negedge clk);
    e_ov = 0; e_wf = 0; e_end = 0; e_w = '0; e_rdy = '0;
    if (m_owner >= 0) begin
      if (m_tag) begin
        e_ov = 1;
        e_w  = {8'(m_owner), 8'(m_seq[m_owner])};
      end else begin
        e_end = in_last[m_owner] || (m_beats == MAX_BURST - 1);
        e_ov  = in_valid[m_owner];
        e_w   = in_word[m_owner*W +: W];
        e_wf  = in_valid[m_owner] && e_end;
        e_rdy[m_owner] = out_rdy;
      end
    end
    act_v = {busy, out_valid, out_wr_file, in_rdy, grant_idx, burst_total, out_valid ? out_word : 16'h0};
    exp_v = {m_owner >= 0, e_ov, e_wf, e_rdy, 2'(m_g), 32'(m_total), e_ov ? e_w : 16'h0};
    check("cycle", 64'(act_v), 64'(exp_v));
    seen_word = out_word;
    if (out_valid && out_rdy) log_q.push_back({out_wr_file, out_word});
    if (sb_on && m_owner >= 0 && !m_tag && out_valid && out_rdy) begin
      check("sb_word", out_word, {4'(m_owner), 12'(exp_serial[m_owner])});
      exp_serial[m_owner]++;
    end
    @(posedge clk);
    for (int i = 0; i < NUM_CH; i++)
      if (in_valid[i] && e_rdy[i]) begin
        void'(src_w[i].pop_front());
        void'(src_l[i].pop_front());
        hold[i] = 0;
      end
    if (m_owner < 0) begin
      found = 0;
      if (enable)
        for (int k = 0; k < NUM_CH; k++) begin
          c = (m_rr + k) % NUM_CH;
          if (!found && in_valid[c]) begin
            found = 1; m_owner = c; m_g = c; m_tag = 1;
          end
        end
    end else if (m_tag) begin
      if (out_rdy) begin m_tag = 0; m_beats = 0; end
    end else if (in_valid[m_owner] && out_rdy) begin
      if (e_end) begin
        m_seq[m_owner] = (m_seq[m_owner] + 1) % 256;
        m_rr = (m_owner + 1) % NUM_CH;
        m_total++;
        m_owner = -1;
      end else begin
        m_beats++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    #2 async_reset_n = 1'b0;
    #1 check("reset_outputs",
             {busy, out_valid, out_wr_file, in_rdy, grant_idx, burst_total, out_word}, '0);
    m_owner = -1; m_tag = 0; m_beats = 0; m_rr = 0; m_g = 0; m_total = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_seq[i] = 0; hold[i] = 0;
      src_w[i].delete(); src_l[i].delete();
    end
    in_valid = '0; in_last = '0; in_word = '0;
    log_q.delete();
    @(negedge clk);
    async_reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((m_owner >= 0 || pending()) && n < budget) begin
      if (rdy_mode == 1)      out_rdy = ~out_rdy;
      else if (rdy_mode == 2) out_rdy = ($urandom_range(99) < 70);
      if (en_mode == 2)       enable = ($urandom_range(99) < 85);
      step();
      n++;
    end
    check({name, "_drained"}, 64'(n < budget), 64'(1));
  endtask

  task automatic check_log(string name);
    check({name, "_len"}, log_q.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
      check($sformatf("%s_beat%0d", name, i), log_q[i], exp_log[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, exp_bursts;
    m_owner = -1;

    // Single channel, three words.
    do_reset();
    enable = 1; out_rdy = 1; present_pct = 100; rdy_mode = 0; en_mode = 0;
    push(1, 16'h0011, 0); push(1, 16'h0022, 0); push(1, 16'h0033, 1);
    drain("t1", 40);
    exp_log = '{17'h00100, 17'h00011, 17'h00022, 17'h10033};
    check_log("t1");
    check("t1_total", burst_total, 64'd1);

    // Round-robin over four channels, ch0 twice.
    do_reset();
    push(0, 16'hA000, 1); push(1, 16'hA001, 1); push(2, 16'hA002, 1);
    push(3, 16'hA003, 1); push(0, 16'hA004, 1);
    drain("t2", 60);
    exp_log = '{17'h00000, 17'h1A000, 17'h00100, 17'h1A001, 17'h00200, 17'h1A002,
                17'h00300, 17'h1A003, 17'h00001, 17'h1A004};
    check_log("t2");
    check("t2_total", burst_total, 64'd5);

    // Truncation at MAX_BURST, then the stream stalls with no more data.
    do_reset();
    for (int i = 0; i < 6; i++) push(2, 16'hC000 + 16'(i), 0);
    for (int i = 0; i < 20; i++) step();
    exp_log = '{17'h00200, 17'h0C000, 17'h0C001, 17'h0C002, 17'h1C003,
                17'h00201, 17'h0C004, 17'h0C005};
    check_log("t3");
    check("t3_total", burst_total, 64'd1);
    check("t3_stalled_busy", busy, 64'd1);

    // Tag held under backpressure, then out_rdy toggling in DATA.
    do_reset();
    push(3, 16'hD000, 0); push(3, 16'hD001, 0); push(3, 16'hD002, 1);
    out_rdy = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_tag_hold", seen_word, 16'h0300);
    end
    check("t4_no_xfer", log_q.size(), 0);
    out_rdy = 1;
    step();
    rdy_mode = 1;
    drain("t4", 60);
    rdy_mode = 0; out_rdy = 1;
    exp_log = '{17'h00300, 17'h0D000, 17'h0D001, 17'h1D002};
    check_log("t4");

    // Reset mid-burst after two data beats.
    do_reset();
    push(2, 16'hE000, 0); push(2, 16'hE001, 0); push(2, 16'hE002, 1);
    for (int i = 0; i < 4; i++) step();
    exp_log = '{17'h00200, 17'h0E000, 17'h0E001};
    check_log("t5_pre");
    do_reset();
    push(0, 16'hF000, 1); push(3, 16'hF300, 1);
    drain("t5", 40);
    exp_log = '{17'h00000, 17'h1F000, 17'h00300, 17'h1F300};
    check_log("t5_post");
    check("t5_total", burst_total, 64'd2);

    // enable dropped mid-burst: burst finishes, no new grant until enable returns.
    do_reset();
    push(1, 16'h6001, 0); push(1, 16'h6002, 0); push(1, 16'h6003, 1);
    step(); step();
    enable = 0;
    drain("t6a", 40);
    push(2, 16'h6200, 1);
    for (int i = 0; i < 10; i++) step();
    check("t6_idle_busy", busy, 64'd0);
    check("t6_idle_len", log_q.size(), 4);
    enable = 1;
    drain("t6b", 40);
    exp_log = '{17'h00100, 17'h06001, 17'h06002, 17'h16003, 17'h00200, 17'h16200};
    check_log("t6");

    // Randomized traffic with truncation, backpressure and gaps.
    do_reset();
    sb_on = 1; exp_bursts = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp_serial[ch] = 0; produced[ch] = 0;
      while (produced[ch] < 20 + $urandom_range(10)) begin
        len = $urandom_range(1, 7);
        for (int j = 0; j < len; j++) begin
          push(ch, {4'(ch), 12'(produced[ch])}, j == len - 1);
          produced[ch]++;
        end
        exp_bursts += (len + MAX_BURST - 1) / MAX_BURST;
      end
    end
    present_pct = 70; rdy_mode = 2; en_mode = 2;
    drain("rand", 4000);
    for (int ch = 0; ch < NUM_CH; ch++)
      check($sformatf("rand_consumed_ch%0d", ch), exp_serial[ch], produced[ch]);
    check("rand_bursts", burst_total, exp_bursts);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/capture_write_arbiter.md
Name: capture_write_arbiter

Overview:
- Shares one grc_word_writer instance among NUM_CH capture streams; sits directly upstream of the writer.
- Grants bursts round-robin and precedes each burst with a tag word identifying the channel and a per-channel burst sequence number.
- Asserts the writer's wr_file on the final beat of every burst, so each burst is flushed to the file as one record.

Parameters:
- NUM_CH, 4: number of requesting channels, 2..16.
- NUM_BYTES, 2: bytes per word, >=2; W = NUM_BYTES*8.
- MAX_BURST, 256: maximum data beats per grant, >=2.

Ports:
- clk  in  1  clock
- async_reset_n  in  1  asynchronous active-low reset
- enable  in  1  permits new grants
- in_valid  in  NUM_CH  per-channel word valid
- in_word  in  NUM_CH*W  per-channel word; channel i occupies [i*W +: W]
- in_last  in  NUM_CH  per-channel end-of-burst marker, qualified by in_valid
- in_rdy  out  NUM_CH  per-channel ready
- out_valid  out  1  to writer valid
- out_word  out  W  to writer word
- out_wr_file  out  1  to writer wr_file
- out_rdy  in  1  from writer rdy_o
- grant_idx  out  clog2(NUM_CH)  currently or last granted channel
- busy  out  1  high in TAG or DATA state
- burst_total  out  32  count of completed bursts, wraps

Behaviour:
- Reset (async assert, sync release): state IDLE, rr_ptr=0, grant_idx=0, all seq[i]=0, beat_cnt=0, burst_total=0. All outputs 0.
- Transfer on an output beat = out_valid & out_rdy.
- IDLE state:
  - out_valid=0, in_rdy=0.
  - If enable and any in_valid: grant the first requesting channel searching from rr_ptr upward with wrap; register grant_idx; go to TAG next cycle.
- TAG state:
  - out_valid=1.
  - out_word = {grant_idx zero-extended to 8 bits in [W-1:W-8], seq[grant_idx] in [W-9:0]}.
  - out_wr_file=0, in_rdy=0.
  - On transfer: beat_cnt=0, go to DATA.
- DATA state (g = grant_idx):
  - Combinational pass-through: out_valid=in_valid[g], out_word=in_word[g], in_rdy[g]=out_rdy, all other in_rdy=0.
  - out_wr_file = in_valid[g] & (in_last[g] | beat_cnt==MAX_BURST-1). It is never high while out_valid is low.
  - On a transfer without end: beat_cnt+1.
  - On a transfer with end: seq[g]+1 (wraps at W-8 bits), rr_ptr=(g+1) mod NUM_CH, burst_total+1, go to IDLE.
- Latency: first data beat is accepted no earlier than 2 cycles after the grant cycle. The tag costs one beat; IDLE costs one bubble cycle between bursts.
- Backpressure:
  - out_rdy low holds the tag word stable.
  - out_rdy low in DATA forces in_rdy[g] low; the source must hold its word.
- enable only gates new grants. Deasserting enable in TAG or DATA lets the burst complete.
- in_last on a non-granted channel is ignored.
- A truncated burst (MAX_BURST reached, in_last not seen): the remainder of the stream is carried in the channel's next grant under a new tag.
- A granted channel with in_valid low stalls the arbiter; no timeout is applied.
- Async reset mid-burst aborts immediately. The partial burst is lost with no wr_file, and outputs return to reset values.

Test Plan:
1. Ch1 only, 3 words 0x0011,0x0022,0x0033 with last on the third, out_rdy=1 -> out_word sequence 0x0100,0x0011,0x0022,0x0033; out_wr_file high only on 0x0033; seq[1]=1; burst_total=1.
2. All 4 channels valid, each sending 1-word bursts with last -> grant order 0,1,2,3,0; tags 0x0000,0x0100,0x0200,0x0300,0x0001.
3. MAX_BURST=4, ch2 streams 6 words without last -> tag, 4 data words with wr_file on the 4th, IDLE, tag 0x0201, remaining 2 words.
4. Tag-phase out_rdy low for 5 cycles, then out_rdy toggling every cycle in DATA -> tag held stable; in_rdy[g] mirrors out_rdy; no word duplicated or lost (bench compares against a scoreboard).
5. async_reset_n pulsed low mid-DATA after 2 beats -> outputs 0 in the same cycle; after release, next grant starts from ch0 with seq 0.
6. enable dropped during a burst -> burst completes with wr_file, then the arbiter stays in IDLE despite pending in_valid until enable returns.
